// File: rtl/stickyx_intr.sv
// Sticky event / interrupt register bank. NCH channels of WIDTH W1C event
// bits with per-bit masks, a read-only summary and a registered interrupt.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   evnt        NCH*WIDTH event inputs, channel c at evnt[c*WIDTH +: WIDTH]
//   upact       1 = normal mode, 0 = diagnostic (writes load sticky bits)
//   upen/upws/uprs/upa/updi  CPU access strobe, qualifiers, address, data
//   updo/upack  registered read data and access acknowledge
//   chirq/irq   registered per-channel and global interrupt
module stickyx_intr #(
  parameter int               WIDTH    = 8,
  parameter int               NCH      = 4,
  parameter int               AW       = 8,
  parameter int               EDGE     = 0,
  parameter logic [WIDTH-1:0] MASK_RST = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] evnt,
  input  logic                 upact,
  input  logic                 upen,
  input  logic                 upws,
  input  logic                 uprs,
  input  logic [AW-1:0]        upa,
  input  logic [WIDTH-1:0]     updi,
  output logic [WIDTH-1:0]     updo,
  output logic                 upack,
  output logic [NCH-1:0]       chirq,
  output logic                 irq
);

  logic [NCH-1:0][WIDTH-1:0] sticky_q, sticky_d;
  logic [NCH-1:0][WIDTH-1:0] mask_q, mask_d;
  logic [NCH*WIDTH-1:0]      evnt_d_q, evnt_d_d;
  logic [WIDTH-1:0]          updo_q, updo_d;
  logic                      upack_q, upack_d;
  logic [NCH-1:0]            chirq_q, chirq_d;
  logic                      irq_q, irq_d;

  logic                      wr, rd;
  logic [NCH*WIDTH-1:0]      ev;
  logic [WIDTH-1:0]          rdata;
  logic                      hit_s, hit_m;

  assign wr = upen & upws;
  assign rd = upen & uprs;

  always_comb begin
    evnt_d_d = evnt;
    ev       = (EDGE != 0) ? (evnt & ~evnt_d_q) : evnt;
    sticky_d = sticky_q;
    mask_d   = mask_q;
    chirq_d  = '0;
    rdata    = '0;
    hit_s    = 1'b0;
    hit_m    = 1'b0;

    for (int c = 0; c < NCH; c++) begin
      chirq_d[c] = |(sticky_q[c] & mask_q[c]);
      hit_s = (upa == AW'(2 * c));
      hit_m = (upa == AW'(2 * c + 1));

      // Normal mode: a same-cycle event beats the W1C clear.
      if (upact) begin
        if (wr && hit_s)
          sticky_d[c] = ev[c*WIDTH +: WIDTH]
                      | (sticky_q[c] & ~updi);
        else
          sticky_d[c] = ev[c*WIDTH +: WIDTH]
                      | sticky_q[c];
      end else if (wr && hit_s) begin
        sticky_d[c] = updi;
      end

      if (wr && hit_m)
        mask_d[c] = updi;

      if (hit_s)
        rdata = sticky_q[c];
      if (hit_m)
        rdata = mask_q[c];
    end

    if (upa == AW'(2 * NCH))
      rdata = WIDTH'(chirq_d);

    updo_d  = rd ? rdata : '0;
    upack_d = wr | rd;
    irq_d   = |chirq_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
      mask_q   <= {NCH{MASK_RST}};
      evnt_d_q <= '0;
      updo_q   <= '0;
      upack_q  <= 1'b0;
      chirq_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      evnt_d_q <= evnt_d_d;
      updo_q   <= updo_d;
      upack_q  <= upack_d;
      chirq_q  <= chirq_d;
      irq_q    <= irq_d;
    end
  end

  assign updo  = updo_q;
  assign upack = upack_q;
  assign chirq = chirq_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_stickyx_intr.sv
// Directed bench for stickyx_intr: a level-mode bank (index 0) and an
// edge-mode bank with all masks reset to 0xFF (index 1).
module tb_stickyx_intr;

  logic        clk;
  logic        rst_n;
  logic [31:0] evnt  [2];
  logic        upact [2];
  logic        upen  [2];
  logic        upws  [2];
  logic        uprs  [2];
  logic [7:0]  upa   [2];
  logic [7:0]  updi  [2];
  logic [7:0]  updo  [2];
  logic        upack [2];
  logic [3:0]  chirq [2];
  logic        irq   [2];

  int checks   = 0;
  int failures = 0;

  string      tq[$];
  logic [7:0] dq[$];

  stickyx_intr #(
    .WIDTH(8), .NCH(4), .AW(8), .EDGE(0), .MASK_RST(8'h00)
  ) u_lvl (
    .clk(clk), .rst_n(rst_n), .evnt(evnt[0]), .upact(upact[0]),
    .upen(upen[0]), .upws(upws[0]), .uprs(uprs[0]), .upa(upa[0]),
    .updi(updi[0]), .updo(updo[0]), .upack(upack[0]),
    .chirq(chirq[0]), .irq(irq[0])
  );

  stickyx_intr #(
    .WIDTH(8), .NCH(4), .AW(8), .EDGE(1), .MASK_RST(8'hFF)
  ) u_edg (
    .clk(clk), .rst_n(rst_n), .evnt(evnt[1]), .upact(upact[1]),
    .upen(upen[1]), .upws(upws[1]), .uprs(uprs[1]), .upa(upa[1]),
    .updi(updi[1]), .updo(updo[1]), .upack(upack[1]),
    .chirq(chirq[1]), .irq(irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access; the expected read data is queued at drive time and
  // retired when the acknowledge comes back.
  task automatic access(input int d, input bit w, input bit r,
                        input logic [7:0] a, input logic [7:0] di,
                        input logic [7:0] exp, input string tag);
    string      t;
    logic [7:0] e;
    upen[d] = 1'b1;
    upws[d] = w;
    uprs[d] = r;
    upa[d]  = a;
    updi[d] = di;
    tq.push_back(tag);
    dq.push_back(r ? exp : 8'h00);
    step();
    upen[d] = 1'b0;
    upws[d] = 1'b0;
    uprs[d] = 1'b0;
    t = tq.pop_front();
    e = dq.pop_front();
    chk({t, "_ack"}, 32'(upack[d]), 32'(1));
    chk(t, 32'(updo[d]), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      evnt[d]  = '0;
      upact[d] = 1'b1;
      upen[d]  = 1'b0;
      upws[d]  = 1'b0;
      uprs[d]  = 1'b0;
      upa[d]   = '0;
      updi[d]  = '0;
    end
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_updo", 32'(updo[d]), 32'(0));
      chk("rst_upack", 32'(upack[d]), 32'(0));
      chk("rst_chirq", 32'(chirq[d]), 32'(0));
      chk("rst_irq", 32'(irq[d]), 32'(0));
    end
    rst_n = 1'b1;
    step();
    access(1, 0, 1, 8'd1, 8'h00, 8'hFF, "rst_mask_edg");
    access(0, 0, 1, 8'd1, 8'h00, 8'h00, "rst_mask_lvl");

    // level event on channel 2 bit 3
    access(0, 1, 0, 8'd5, 8'h08, 8'h00, "t1_wr_mask2");
    evnt[0][19] = 1'b1;
    step();
    evnt[0][19] = 1'b0;
    chk("t1_chirq_n1", 32'(chirq[0]), 32'(0));
    step();
    chk("t1_chirq_n2", 32'(chirq[0]), 32'(4'b0100));
    chk("t1_irq_n2", 32'(irq[0]), 32'(1));
    access(0, 0, 1, 8'd4, 8'h00, 8'h08, "t1_rd_sticky2");
    access(0, 0, 1, 8'd8, 8'h00, 8'h04, "t1_rd_summary");
    access(0, 1, 0, 8'd8, 8'h00, 8'h00, "t1_wr_summary");
    access(0, 0, 1, 8'd8, 8'h00, 8'h04, "t1_rd_summary2");

    // W1C against a held event, then with the event gone
    evnt[0][19] = 1'b1;
    access(0, 1, 0, 8'd4, 8'h08, 8'h00, "t2_w1c_held");
    access(0, 0, 1, 8'd4, 8'h00, 8'h08, "t2_rd_held");
    evnt[0][19] = 1'b0;
    access(0, 1, 0, 8'd4, 8'h08, 8'h00, "t2_w1c");
    chk("t2_irq_w1", 32'(irq[0]), 32'(1));
    step();
    chk("t2_irq_w2", 32'(irq[0]), 32'(0));
    chk("t2_chirq_w2", 32'(chirq[0]), 32'(0));
    access(0, 0, 1, 8'd4, 8'h00, 8'h00, "t2_rd_clr");

    // diagnostic mode
    upact[0] = 1'b0;
    evnt[0][7:0] = 8'hFF;
    access(0, 1, 0, 8'd0, 8'hA5, 8'h00, "t4_wr_diag");
    access(0, 0, 1, 8'd0, 8'h00, 8'hA5, "t4_rd_diag");
    upact[0] = 1'b1;
    step();
    access(0, 0, 1, 8'd0, 8'h00, 8'hFF, "t4_rd_norm");
    evnt[0][7:0] = 8'h00;
    access(0, 1, 0, 8'd0, 8'hFF, 8'h00, "t4_w1c");
    access(0, 0, 1, 8'd0, 8'h00, 8'h00, "t4_rd_clr");

    // unmapped, unqualified strobe, write+read together
    access(0, 0, 1, 8'd9, 8'h00, 8'h00, "t5_rd_unmap");
    upen[0] = 1'b1;
    upa[0]  = 8'd0;
    step();
    upen[0] = 1'b0;
    chk("t5_noqual_ack", 32'(upack[0]), 32'(0));
    access(0, 1, 0, 8'd1, 8'h11, 8'h00, "t5_wr_mask0");
    access(0, 1, 1, 8'd1, 8'h3C, 8'h11, "t5_wrrd_old");
    access(0, 0, 1, 8'd1, 8'h00, 8'h3C, "t5_rd_new");

    // edge mode: held level latches once only
    evnt[1][7:0] = 8'hFF;
    for (int i = 0; i < 10; i++) step();
    access(1, 0, 1, 8'd0, 8'h00, 8'hFF, "t3_rd_rise");
    access(1, 1, 0, 8'd0, 8'hFF, 8'h00, "t3_w1c");
    step();
    step();
    access(1, 0, 1, 8'd0, 8'h00, 8'h00, "t3_rd_held");
    evnt[1][7:0] = 8'h00;
    step();
    evnt[1][0] = 1'b1;
    step();
    access(1, 0, 1, 8'd0, 8'h00, 8'h01, "t3_rd_rise2");
    chk("t3_chirq", 32'(chirq[1]), 32'(4'b0001));

    // reset in the middle of a read
    evnt[1] = '0;
    evnt[1][8] = 1'b1;
    access(0, 1, 0, 8'd7, 8'hFF, 8'h00, "t6_wr_mask3");
    evnt[0][24] = 1'b1;
    step();
    evnt[0][24] = 1'b0;
    step();
    chk("t6_irq_pre", 32'(irq[0]), 32'(1));
    upen[0] = 1'b1;
    uprs[0] = 1'b1;
    upa[0]  = 8'd7;
    step();
    rst_n = 1'b0;
    step();
    chk("t6_upack", 32'(upack[0]), 32'(0));
    chk("t6_updo", 32'(updo[0]), 32'(0));
    chk("t6_irq", 32'(irq[0]), 32'(0));
    chk("t6_chirq", 32'(chirq[0]), 32'(0));
    upen[0] = 1'b0;
    uprs[0] = 1'b0;
    rst_n = 1'b1;
    step();
    access(0, 0, 1, 8'd6, 8'h00, 8'h00, "t6_rd_sticky3");
    access(0, 0, 1, 8'd7, 8'h00, 8'h00, "t6_rd_mask3");
    access(0, 0, 1, 8'd1, 8'h00, 8'h00, "t6_rd_mask0");
    chk("t6_irq_post", 32'(irq[0]), 32'(0));
    access(1, 0, 1, 8'd0, 8'h00, 8'h00, "t6_edg_sticky0");
    access(1, 0, 1, 8'd2, 8'h00, 8'h01, "t6_edg_rel_rise");
    access(1, 0, 1, 8'd3, 8'h00, 8'hFF, "t6_edg_mask1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
